// File: rtl/cnu_arith_pkg.sv
// cnu_arith_pkg
//   Shared arithmetic helpers for the CNU/VNU message datapath.
//   seg_w   : ceil(width/stages), nominal ripple segment width
//   seg_lo  : LSB index of segment k. Each segment is guaranteed to be
//             at least one bit wide.
//   sat_max : most positive two's-complement value of a given width
//   sat_min : most negative two's-complement value of a given width
//   Widths up to 64 bits are supported by the saturation helpers.
package cnu_arith_pkg;

  function automatic int seg_w(input int width, input int stages);
    return (width + stages - 1) / stages;
  endfunction

  // Segments 0..stages-2 take seg_w bits and the last segment takes the
  // remainder. The cap only matters for width/stages combinations where
  // ceil-sized segments would leave the tail segments empty. In that case
  // the upper segments shrink to one bit each.
  function automatic int seg_lo(input int width, input int stages, input int k);
    int lo;
    int cap;
    lo  = k * seg_w(width, stages);
    cap = width - (stages - k);
    return (lo < cap) ? lo : cap;
  endfunction

  function automatic logic [63:0] sat_max(input int width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_min(input int width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pipelined_seg_adder_rca_segment.sv
// rca_segment
//   W-bit ripple-carry adder segment. It forms one pipeline slice of
//   pipelined_seg_adder.
//   a, b : W-bit operand slices
//   cin  : carry into bit 0 of the slice
//   s    : W-bit sum slice
//   cout : carry out of the slice MSB
module rca_segment #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] carry;

  assign carry[0] = cin;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign s[gi]         = a[gi] ^ b[gi] ^ carry[gi];
      assign carry[gi + 1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
    end
  endgenerate

  assign cout = carry[W];

endmodule

// File: rtl/pipelined_seg_adder.sv
// pipelined_seg_adder
//   Pipelined two's-complement adder/subtractor with valid/ready flow
//   control. The WIDTH-bit carry chain is cut into STAGES ripple segments,
//   and each segment is followed by a register boundary. Latency is STAGES
//   cycles and throughput is one result per cycle.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   in_valid, in_ready  : input handshake; a, b, sub, sat are sampled on transfer
//   a, b                : WIDTH-bit operands
//   sub                 : 1 computes a-b, 0 computes a+b
//   sat                 : 1 clamps the result to the signed range on overflow
//   out_valid, out_ready: output handshake
//   sum                 : result (raw or saturated)
//   cout                : carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf                 : signed overflow. This flag is raised whether or not
//                         sat is set.
module pipelined_seg_adder
  import cnu_arith_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int               LAST    = STAGES - 1;
  localparam logic [WIDTH-1:0] MAX_POS = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(sat_min(WIDTH));

  logic [STAGES-1:0] v_vec;  // stage valid bits, gathered from the stage blocks
  logic [STAGES-1:0] adv;    // stage k may load this cycle

  genvar gi;

  // The recursive form adv[k] = !v[k] | adv[k+1] unrolls to: stage k
  // advances unless every stage from k up to the output is occupied and
  // the output is stalled. That gives a flat AND/OR per stage with no
  // chained combinational feedback through adv itself.
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_adv
      assign adv[gi] = out_ready | ~(&v_vec[STAGES-1:gi]);
    end
  endgenerate

  assign in_ready = adv[0];

  // Every stage register carries the full operand words and a result word.
  // The result word is correct from bit 0 up to that stage's slice. Stage k
  // reads the upper operand slices from stage k-1 (the skew) and copies the
  // completed lower result bits forward (the deskew). As a result, the word
  // leaving the last stage is fully aligned. The sub control is folded into
  // the effective operand B' and the initial carry at stage 0, so it does
  // not need to travel further. The sat control travels with the data.
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      localparam int LO = seg_lo(WIDTH, STAGES, gi);
      localparam int HI = (gi == STAGES - 1) ? WIDTH - 1
                                             : seg_lo(WIDTH, STAGES, gi + 1) - 1;
      localparam int W  = HI - LO + 1;

      logic             v_in;
      logic [WIDTH-1:0] a_in;
      logic [WIDTH-1:0] b_in;
      logic [WIDTH-1:0] s_in;
      logic             c_in;
      logic             sat_in;

      logic [W-1:0]     seg_s;
      logic             seg_c;
      logic [WIDTH-1:0] s_next;

      logic             v_reg;
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;
      logic [WIDTH-1:0] s_reg;
      logic             c_reg;
      logic             sat_reg;

      if (gi == 0) begin : g_head
        assign v_in   = in_valid;
        assign a_in   = a;
        assign b_in   = sub ? ~b : b;
        assign s_in   = '0;
        assign c_in   = sub;
        assign sat_in = sat;
      end else begin : g_body
        assign v_in   = g_stage[gi - 1].v_reg;
        assign a_in   = g_stage[gi - 1].a_reg;
        assign b_in   = g_stage[gi - 1].b_reg;
        assign s_in   = g_stage[gi - 1].s_reg;
        assign c_in   = g_stage[gi - 1].c_reg;
        assign sat_in = g_stage[gi - 1].sat_reg;
      end

      rca_segment #(
        .W (W)
      ) u_seg (
        .a    (a_in[HI:LO]),
        .b    (b_in[HI:LO]),
        .cin  (c_in),
        .s    (seg_s),
        .cout (seg_c)
      );

      always_comb begin
        s_next        = s_in;
        s_next[HI:LO] = seg_s;
      end

      // A stalled stage keeps its contents. A bubble is allowed to load
      // whatever is upstream, because its v_reg marks it as not valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_reg   <= 1'b0;
          a_reg   <= '0;
          b_reg   <= '0;
          s_reg   <= '0;
          c_reg   <= 1'b0;
          sat_reg <= 1'b0;
        end else if (adv[gi]) begin
          v_reg   <= v_in;
          a_reg   <= a_in;
          b_reg   <= b_in;
          s_reg   <= s_next;
          c_reg   <= seg_c;
          sat_reg <= sat_in;
        end
      end

      assign v_vec[gi] = v_reg;
    end
  endgenerate

  // Output decode. This logic only reads last-stage registers, so the
  // outputs stay stable while the output is held. All registers reset to
  // zero, which makes sum/cout/ovf read as zero during reset.
  logic [WIDTH-1:0] raw;
  logic             a_msb;
  logic             b_msb;

  assign raw   = g_stage[LAST].s_reg;
  assign a_msb = g_stage[LAST].a_reg[WIDTH-1];
  assign b_msb = g_stage[LAST].b_reg[WIDTH-1];

  assign out_valid = g_stage[LAST].v_reg;
  assign cout      = g_stage[LAST].c_reg;
  assign ovf       = (a_msb == b_msb) & (raw[WIDTH-1] != a_msb);

  // Signed overflow can only push toward the sign of a, so a's sign
  // selects which rail to clamp to.
  assign sum = (g_stage[LAST].sat_reg & ovf) ? (a_msb ? MIN_NEG : MAX_POS) : raw;

endmodule

// File: tb/tb_pipelined_seg_adder.sv
// tb_pipelined_seg_adder
//   Directed bench for pipelined_seg_adder with WIDTH=8. Instance 0 uses
//   STAGES=2 for the directed arithmetic and reset steps. Instances 1..3
//   use STAGES=1, 3 and 8 for the backpressure stream.
module tb_pipelined_seg_adder;

  localparam int ND = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid  [ND];
  logic       in_ready  [ND];
  logic       sub       [ND];
  logic       sat       [ND];
  logic       out_valid [ND];
  logic       out_ready [ND];
  logic       cout      [ND];
  logic       ovf       [ND];
  logic [7:0] a         [ND];
  logic [7:0] b         [ND];
  logic [7:0] sum       [ND];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < ND; gi++) begin : g_dut
      localparam int S = (gi == 0) ? 2 : (gi == 1) ? 1 : (gi == 2) ? 3 : 8;
      pipelined_seg_adder #(
        .WIDTH  (8),
        .STAGES (S)
      ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid[gi]),
        .in_ready  (in_ready[gi]),
        .a         (a[gi]),
        .b         (b[gi]),
        .sub       (sub[gi]),
        .sat       (sat[gi]),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .sum       (sum[gi]),
        .cout      (cout[gi]),
        .ovf       (ovf[gi])
      );
    end
  endgenerate

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference result {cout, ovf, sum}. It is computed with integer
  // arithmetic on the signed and unsigned interpretations of the operands.
  function automatic logic [9:0] model(input logic [7:0] x, input logic [7:0] y,
                                       input logic s, input logic t);
    int         ux, uy, full, sx, sy, r;
    logic [7:0] res;
    logic       c, o;
    ux   = x;
    uy   = y;
    full = s ? (ux + (255 - uy) + 1) : (ux + uy);
    c    = (full >= 256);
    sx   = $signed(x);
    sy   = $signed(y);
    r    = s ? (sx - sy) : (sx + sy);
    o    = (r > 127) || (r < -128);
    res  = full[7:0];
    if (t && o) res = (r > 127) ? 8'h7F : 8'h80;
    return {c, o, res};
  endfunction

  // One transaction on instance 0: accept, measure latency, check result.
  task automatic do_one(input string tag, input logic [7:0] xa, input logic [7:0] xb,
                        input logic xs, input logic xt,
                        input logic [7:0] es, input logic ec, input logic eo);
    int n;
    a[0] = xa; b[0] = xb; sub[0] = xs; sat[0] = xt;
    in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept"}, 32'(in_ready[0]), 32'd1);
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid[0] && n < 20);
    chk({tag, "_lat"}, 32'(n), 32'd2);
    chk({tag, "_sum"}, 32'(sum[0]), 32'(es));
    chk({tag, "_cout"}, 32'(cout[0]), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf[0]), 32'(eo));
    $display("[TB] %s: a=%02h b=%02h sub=%0d sat=%0d -> sum=%02h cout=%0d ovf=%0d",
             tag, xa, xb, xs, xt, sum[0], cout[0], ovf[0]);
    @(posedge clk); #1;
  endtask

  // Ten back-to-back transactions. The output stalls for 4 cycles right
  // after the first result has been taken.
  task automatic stream(input int d);
    logic [7:0] va [10];
    logic [7:0] vb [10];
    logic       vs [10];
    logic       vt [10];
    logic [9:0] expq [$];
    logic [9:0] got;
    int         idx, n_out, cyc, stall_left;
    bit         stall_done, acc;
    for (int i = 0; i < 10; i++) begin
      va[i] = 8'($urandom_range(0, 255));
      vb[i] = 8'($urandom_range(0, 255));
      vs[i] = 1'($urandom_range(0, 1));
      vt[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; n_out = 0; cyc = 0; stall_left = 0; stall_done = 0;
    a[d] = va[0]; b[d] = vb[0]; sub[d] = vs[0]; sat[d] = vt[0];
    in_valid[d] = 1'b1; out_ready[d] = 1'b1;
    while (n_out < 10 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid[d]) begin
        got = {cout[d], ovf[d], sum[d]};
        if (expq.size() == 0) begin
          chk($sformatf("s%0d_extra", d), 32'(expq.size()), 32'd1);
        end else begin
          chk($sformatf("s%0d_out%0d", d, n_out), 32'(got), 32'(expq[0]));
          if (out_ready[d]) begin
            $display("[TB] stream%0d out%0d sum=%02h cout=%0d ovf=%0d",
                     d, n_out, sum[d], cout[d], ovf[d]);
            void'(expq.pop_front());
            n_out++;
          end
        end
      end
      if (!out_ready[d]) chk($sformatf("s%0d_stall_in_ready", d), 32'(in_ready[d]), 32'd0);
      acc = in_valid[d] && in_ready[d];
      @(posedge clk); #1;
      if (acc) begin
        expq.push_back(model(va[idx], vb[idx], vs[idx], vt[idx]));
        idx++;
      end
      if (idx < 10) begin
        a[d] = va[idx]; b[d] = vb[idx]; sub[d] = vs[idx]; sat[d] = vt[idx];
        in_valid[d] = 1'b1;
      end else begin
        in_valid[d] = 1'b0;
      end
      if (stall_left > 0) stall_left--;
      if (!stall_done && n_out >= 1) begin
        stall_left = 4;
        stall_done = 1'b1;
      end
      out_ready[d] = (stall_left == 0);
    end
    chk($sformatf("s%0d_count", d), 32'(n_out), 32'd10);
    chk($sformatf("s%0d_left", d), 32'(expq.size()), 32'd0);
    chk($sformatf("s%0d_stalled", d), 32'(stall_done), 32'd1);
    in_valid[d] = 1'b0;
    out_ready[d] = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < ND; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b1;
      a[d] = 8'h00; b[d] = 8'h00; sub[d] = 1'b0; sat[d] = 1'b0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("rst%0d_out_valid", d), 32'(out_valid[d]), 32'd0);
      chk($sformatf("rst%0d_sum", d), 32'(sum[d]), 32'd0);
      chk($sformatf("rst%0d_cout", d), 32'(cout[d]), 32'd0);
      chk($sformatf("rst%0d_ovf", d), 32'(ovf[d]), 32'd0);
      chk($sformatf("rst%0d_in_ready", d), 32'(in_ready[d]), 32'd1);
    end
    @(posedge clk); #1;

    // Directed arithmetic on STAGES=2
    do_one("add_200_100",  8'd200, 8'd100, 1'b0, 1'b0, 8'd44,  1'b1, 1'b0);
    do_one("ovf_sat",      8'd100, 8'd50,  1'b0, 1'b1, 8'd127, 1'b0, 1'b1);
    do_one("ovf_nosat",    8'd100, 8'd50,  1'b0, 1'b0, 8'h96,  1'b0, 1'b1);
    do_one("neg_ovf_sat",  8'h80,  8'hFF,  1'b0, 1'b1, 8'h80,  1'b1, 1'b1);
    do_one("sub_5_10",     8'd5,   8'd10,  1'b1, 1'b0, 8'd251, 1'b0, 1'b0);
    do_one("sub_ovf_sat",  8'h80,  8'h01,  1'b1, 1'b1, 8'h80,  1'b1, 1'b1);
    do_one("sub_ovf_raw",  8'h80,  8'h01,  1'b1, 1'b0, 8'h7F,  1'b1, 1'b1);
    do_one("wrap_ff_01",   8'hFF,  8'h01,  1'b0, 1'b1, 8'h00,  1'b1, 1'b0);
    do_one("sub_0_80_sat", 8'h00,  8'h80,  1'b1, 1'b1, 8'h7F,  1'b0, 1'b1);

    // Backpressure streams on every pipeline depth
    for (int d = 0; d < ND; d++) stream(d);

    // Reset with two transactions in flight on STAGES=2
    @(posedge clk); #1;
    a[0] = 8'h11; b[0] = 8'h22; sub[0] = 1'b0; sat[0] = 1'b0;
    in_valid[0] = 1'b1; out_ready[0] = 1'b0;
    @(posedge clk); #1;
    a[0] = 8'h33; b[0] = 8'h44;
    @(posedge clk); #1;
    in_valid[0] = 1'b0;
    chk("midrst_pre_valid", 32'(out_valid[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("midrst_sum", 32'(sum[0]), 32'd0);
    $display("[TB] mid-flight reset: out_valid=%0d sum=%02h", out_valid[0], sum[0]);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("postrst_idle%0d", i), 32'(out_valid[0]), 32'd0);
    end
    @(posedge clk); #1;
    do_one("postrst_add", 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
